seg_serial_shifter: RTL and testbench

//  Serialises a 64-bit 8-digit seven-segment pattern onto the Sword board's shift-register chain
//  (seg_clk/seg_do/seg_pen/seg_clr_n), downstream of the mipsfpga_sys AHB GPIO segment register.
//  A frame is bit-banged MSB first, then latched to the display. The same block is instanced for the
//  LED chain (led_* pins) with WIDTH=16. Requests arriving mid-frame are held and sent afterwards.

---
 rtl/seg_serial_shifter_if.sv | 24 ++
 rtl/seg_serial_shifter.sv | 164 ++++++++++++++++
 tb/tb_seg_serial_shifter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_serial_shifter_if.sv
// Request/serial-chain signal bundle for seg_serial_shifter.
// Handshake: load is a one-cycle request with no ready; a load while busy is queued (latest wins).
interface seg_serial_shifter_if #(
  parameter int WIDTH = 64
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             seg_clk;
  logic             seg_do;
  logic             seg_pen;
  logic             seg_clr_n;
  logic [1:0]       dbg_state;

  modport master (
    output load, data,
    input  busy, seg_clk, seg_do, seg_pen, seg_clr_n, dbg_state
  );

  modport slave (
    input  load, data,
    output busy, seg_clk, seg_do, seg_pen, seg_clr_n, dbg_state
  );
endinterface

// File: rtl/seg_serial_shifter.sv
// Bit-bangs a WIDTH-bit pattern MSB first onto a shift-register chain, then latches it for display.
// Optional macro SEG_AUTO_REFRESH_EN: periodically re-sends the last frame while idle.
module seg_serial_shifter #(
  parameter int WIDTH   = 64,
  parameter int CLK_DIV = 2,
  parameter int REFRESH = 1000000
) (
  input logic                HCLK,
  input logic                HRESET,
  seg_serial_shifter_if.slave bus
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH);

  if (WIDTH < 2 || CLK_DIV < 1 || REFRESH < 2) begin : g_param_check
    $error("seg_serial_shifter: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOW   = 2'd1,
    S_HIGH  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [DW-1:0]    r_div, w_div_nxt;
  logic [BW-1:0]    r_bitcnt, w_bitcnt_nxt;
  logic [WIDTH-1:0] r_shadow, w_shadow_nxt;
  logic [WIDTH-1:0] r_pend_data, w_pend_data_nxt;
  logic             r_pending, w_pending_nxt;
  logic             r_pen, w_pen_nxt;
  logic             r_clk, w_clk_nxt;
  logic             r_do, w_do_nxt;
  logic             r_clr_n;
  logic             w_start;
  logic             w_div_last;
  logic             w_refresh_hit;

`ifdef SEG_AUTO_REFRESH_EN
  localparam int RW = $clog2(REFRESH);
  logic [RW-1:0] r_refresh;

  assign w_refresh_hit = (r_state == S_IDLE) && (r_refresh == RW'(REFRESH - 1));

  always_ff @(posedge HCLK) begin
    if (HRESET || w_start || r_state != S_IDLE) begin
      r_refresh <= '0;
    end else if (!w_refresh_hit) begin
      r_refresh <= r_refresh + 1'b1;
    end
  end
`else
  assign w_refresh_hit = 1'b0;
`endif

  assign w_div_last = (r_div == DW'(CLK_DIV - 1));

  always_comb begin
    w_state_nxt      = r_state;
    w_div_nxt        = r_div;
    w_bitcnt_nxt     = r_bitcnt;
    w_shadow_nxt     = r_shadow;
    w_pend_data_nxt  = r_pend_data;
    w_pending_nxt    = r_pending;
    w_pen_nxt        = r_pen;
    w_start          = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A fresh load beats an older pending frame; both consume the pending slot.
        if (bus.load) begin
          w_shadow_nxt  = bus.data;
          w_pending_nxt = 1'b0;
          w_start       = 1'b1;
        end else if (r_pending) begin
          w_shadow_nxt  = r_pend_data;
          w_pending_nxt = 1'b0;
          w_start       = 1'b1;
        end else if (w_refresh_hit) begin
          w_start       = 1'b1;
        end
        if (w_start) begin
          w_state_nxt  = S_LOW;
          w_bitcnt_nxt = BW'(WIDTH - 1);
          w_div_nxt    = '0;
          w_pen_nxt    = 1'b0;
        end
      end
      S_LOW: begin
        if (w_div_last) begin
          w_state_nxt = S_HIGH;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_HIGH: begin
        if (w_div_last) begin
          w_div_nxt = '0;
          if (r_bitcnt == '0) begin
            w_state_nxt = S_LATCH;
          end else begin
            w_state_nxt  = S_LOW;
            w_bitcnt_nxt = r_bitcnt - 1'b1;
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      default: begin
        if (w_div_last) begin
          w_state_nxt = S_IDLE;
          w_div_nxt   = '0;
          w_pen_nxt   = 1'b1;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
    endcase

    if (r_state != S_IDLE && bus.load) begin
      w_pending_nxt   = 1'b1;
      w_pend_data_nxt = bus.data;
    end

    // Pin values are registered from next-state so the chain never sees decode glitches.
    w_clk_nxt = (w_state_nxt == S_HIGH);
    w_do_nxt  = (w_state_nxt == S_LOW || w_state_nxt == S_HIGH) ? w_shadow_nxt[w_bitcnt_nxt] : 1'b0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bitcnt    <= '0;
      r_shadow    <= '0;
      r_pend_data <= '0;
      r_pending   <= 1'b0;
      r_pen       <= 1'b0;
      r_clk       <= 1'b0;
      r_do        <= 1'b0;
      r_clr_n     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_shadow    <= w_shadow_nxt;
      r_pend_data <= w_pend_data_nxt;
      r_pending   <= w_pending_nxt;
      r_pen       <= w_pen_nxt;
      r_clk       <= w_clk_nxt;
      r_do        <= w_do_nxt;
      r_clr_n     <= 1'b1;
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.seg_clk   = r_clk;
  assign bus.seg_do    = r_do;
  assign bus.seg_pen   = r_pen;
  assign bus.seg_clr_n = r_clr_n;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_seg_serial_shifter.sv
// Directed bench for seg_serial_shifter: 64-bit/CLK_DIV=2 and 16-bit/CLK_DIV=1 instances,
// frame contents checked by a negedge monitor against an expected queue.
module tb_seg_serial_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [63:0] exp_q[$];
  logic [15:0] exp16_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_serial_shifter_if #(.WIDTH(64)) bus64 ();
  seg_serial_shifter_if #(.WIDTH(16)) bus16 ();

  seg_serial_shifter #(.WIDTH(64), .CLK_DIV(2), .REFRESH(500)) u_dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus64)
  );

  seg_serial_shifter #(.WIDTH(16), .CLK_DIV(1), .REFRESH(1000000)) u_dut16 (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus64.busy;
      1:       return bus64.seg_clk;
      2:       return bus16.busy;
      3:       return bus16.seg_clk;
      default: return 1'b0;
    endcase
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input int sel, input logic val, input int budget, input string name,
                          output int at);
    int n = 0;
    at = -1;
    forever begin
      @(negedge clk);
      if (sig(sel) === val) begin
        at = cyc;
        break;
      end
      n++;
      if (n >= budget) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout after %0d cycles", name, budget);
        break;
      end
    end
  endtask

  // Call right after a posedge+1; returns with load dropped one cycle later.
  task automatic load64(input logic [63:0] d, output int lc);
    bus64.load = 1'b1;
    bus64.data = d;
    lc = cyc;
    tick(1);
    bus64.load = 1'b0;
  endtask

  // ---------------- monitor: 64-bit chain ----------------
  logic        m_pclk = 1'b0, m_pbusy = 1'b0, m_pdo = 1'b0, m_moved = 1'b0;
  logic [63:0] m_fr = '0;
  int          m_nb = 0;
  int          rises64 = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_nb = 0; m_fr = '0; m_moved = 1'b0; m_pbusy = 1'b0; m_pclk = 1'b0; m_pdo = 1'b0;
    end else begin
      if (bus64.seg_clk && !m_pclk) begin
        m_fr = {m_fr[62:0], bus64.seg_do};
        m_nb++;
        rises64++;
      end
      if (bus64.seg_clk && m_pclk && bus64.seg_do !== m_pdo) m_moved = 1'b1;
      if (!bus64.busy && m_pbusy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL frame64 unexpected: got %h expected none", m_fr);
        end else begin
          check("frame64 data", m_fr, exp_q.pop_front());
          check("frame64 bits", 64'(m_nb), 64'd64);
          check("frame64 do stable while clk high", 64'(m_moved), 64'd0);
        end
        m_nb = 0; m_fr = '0; m_moved = 1'b0;
      end
      m_pclk  = bus64.seg_clk;
      m_pbusy = bus64.busy;
      m_pdo   = bus64.seg_do;
    end
  end

  // ---------------- monitor: 16-bit chain ----------------
  logic        n_pclk = 1'b0, n_pbusy = 1'b0;
  logic [15:0] n_fr = '0;
  int          n_nb = 0;

  always @(negedge clk) begin
    if (rst) begin
      n_nb = 0; n_fr = '0; n_pbusy = 1'b0; n_pclk = 1'b0;
    end else begin
      if (bus16.seg_clk && !n_pclk) begin
        n_fr = {n_fr[14:0], bus16.seg_do};
        n_nb++;
      end
      if (!bus16.busy && n_pbusy) begin
        if (exp16_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL frame16 unexpected: got %h expected none", n_fr);
        end else begin
          check("frame16 data", 64'(n_fr), 64'(exp16_q.pop_front()));
          check("frame16 bits", 64'(n_nb), 64'd16);
        end
        n_nb = 0; n_fr = '0;
      end
      n_pclk  = bus16.seg_clk;
      n_pbusy = bus16.busy;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int L, L2, at, e, r0;
    logic seen;
    bus64.load = 1'b0; bus64.data = '0;
    bus16.load = 1'b0; bus16.data = '0;

    // Reset behaviour
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst busy", 64'(bus64.busy), 0);
    check("rst seg_clk/do/pen", {61'd0, bus64.seg_clk, bus64.seg_do, bus64.seg_pen}, 0);
    check("rst seg_clr_n", 64'(bus64.seg_clr_n), 0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("clr_n before first sampled release", 64'(bus64.seg_clr_n), 0);
    @(negedge clk);
    check("clr_n after release", 64'(bus64.seg_clr_n), 1);
    check("clr_n16 after release", 64'(bus16.seg_clr_n), 1);
    check("busy after release", 64'(bus64.busy), 0);
    check("pen after release", 64'(bus64.seg_pen), 0);

    // Single frame timing
    sync();
    load64(64'hA5A5_0000_FFFF_1234, L);
    exp_q.push_back(64'hA5A5_0000_FFFF_1234);
    @(negedge clk);
    check("busy cycle 1", 64'(bus64.busy), 1);
    check("pen low while shifting", 64'(bus64.seg_pen), 0);
    wait_for(1, 1'b1, 20, "first rise", at);
    check("first rise cycle", 64'(at - L), 64'd3);
    wait_for(0, 1'b0, 400, "frame end", at);
    check("busy fall cycle", 64'(at - L), 64'd259);
    check("pen at busy fall", 64'(bus64.seg_pen), 1);

    // Mid-frame loads: latest wins, intermediate dropped
    sync();
    load64(64'h1, L);
    exp_q.push_back(64'h1);
    tick(19);
    load64(64'h2, L2);
    tick(19);
    load64(64'h3, L2);
    exp_q.push_back(64'h3);
    wait_for(0, 1'b0, 400, "pend frame1 end", at);
    check("pend frame1 end", 64'(at - L), 64'd259);
    wait_for(0, 1'b1, 10, "pend frame2 start", at);
    check("pend frame2 start", 64'(at - L), 64'd260);
    wait_for(0, 1'b0, 400, "pend frame2 end", at);
    check("pend frame2 end", 64'(at - L), 64'd518);

    // Load in the final latch cycle is queued, not dropped
    sync();
    load64(64'h8000_0000_0000_0001, L);
    exp_q.push_back(64'h8000_0000_0000_0001);
    tick(257);
    load64(64'hDEAD_BEEF_0123_4567, L2);
    exp_q.push_back(64'hDEAD_BEEF_0123_4567);
    check("late load cycle", 64'(L2 - L), 64'd258);
    wait_for(0, 1'b0, 10, "edge frame1 end", at);
    check("edge frame1 end", 64'(at - L), 64'd259);
    wait_for(0, 1'b1, 10, "edge frame2 start", at);
    check("edge frame2 start", 64'(at - L), 64'd260);
    wait_for(0, 1'b0, 400, "edge frame2 end", at);
    check("edge frame2 end", 64'(at - L), 64'd518);

    // Reset mid-frame with a pending request outstanding
    sync();
    load64(64'hFFFF_FFFF_FFFF_FFFF, L);
    tick(49);
    load64(64'h5555_5555_5555_5555, L2);
    tick(49);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort cycle", 64'(cyc - L), 64'd101);
    check("abort seg_clk", 64'(bus64.seg_clk), 0);
    check("abort seg_pen", 64'(bus64.seg_pen), 0);
    check("abort busy", 64'(bus64.busy), 0);
    check("abort seg_do", 64'(bus64.seg_do), 0);
    sync();
    rst = 1'b0;
    r0 = rises64;
    tick(300);
    check("no edges after abort", 64'(rises64 - r0), 0);
    check("idle after abort", 64'(bus64.busy), 0);

    // 16-bit chain, CLK_DIV=1
    bus16.load = 1'b1;
    bus16.data = 16'h8001;
    L = cyc;
    exp16_q.push_back(16'h8001);
    tick(1);
    bus16.load = 1'b0;
    wait_for(3, 1'b1, 20, "w16 first rise", at);
    check("w16 first rise", 64'(at - L), 64'd2);
    wait_for(2, 1'b0, 100, "w16 busy fall", at);
    check("w16 busy fall", 64'(at - L), 64'd34);
    check("w16 pen", 64'(bus16.seg_pen), 1);

    // Auto refresh (or its absence)
    sync();
    load64(64'h0F0F_3C3C_A5A5_7E7E, L);
    exp_q.push_back(64'h0F0F_3C3C_A5A5_7E7E);
    wait_for(0, 1'b0, 400, "refresh base frame", e);
    check("refresh base frame end", 64'(e - L), 64'd259);
`ifdef SEG_AUTO_REFRESH_EN
    exp_q.push_back(64'h0F0F_3C3C_A5A5_7E7E);
    wait_for(0, 1'b1, 1000, "refresh start", at);
    check("refresh start", 64'(at - e), 64'd500);
    wait_for(0, 1'b0, 400, "refresh end", at);
    check("refresh end", 64'(at - e), 64'd758);
`else
    seen = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      if (bus64.busy) seen = 1'b1;
    end
    check("no auto resend", 64'(seen), 0);
`endif

    tick(2);
    check("exp64 queue drained", 64'(exp_q.size()), 0);
    check("exp16 queue drained", 64'(exp16_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
